// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
package lsu_pkg;

  // Sequencing states of the unit
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/lsu_lane.sv
// Lane steering: little-endian load extract/extend and store merge.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] word_in,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // Shift the addressed lane(s) down to bit 0, then extend to 32 bits
  always_comb begin
    byte_sh = word_in >> {addr_lo, 3'b000};
    half_sh = word_in >> {addr_lo[1], 4'b0000};
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_sh[7]}}, byte_sh[7:0]};
      SZ_HALF: load_data = {{16{sign_ext & half_sh[15]}}, half_sh[15:0]};
      default: load_data = word_in;
    endcase
  end

  // Overlay the store data onto the captured word; untouched lanes are kept
  always_comb begin
    store_data = word_in;
    case (size)
      SZ_BYTE: store_data[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: store_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: store_data = wdata;
      default: store_data = word_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU request at a time, performs a
// read and/or write against a combinational-read word memory and
// returns a single-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic        mem_writeEnable,
  output logic [31:0] mem_dataIn,
  input  logic [31:0] mem_dataOut
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        write_q, write_d;
  logic        err_q, err_d;

  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_data;

  // Reject illegal sizes, misaligned accesses and out-of-range words
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) begin
      req_err = 1'b1;
    end
  end

  lsu_lane u_lane (
    .size       (size_q),
    .sign_ext   (signed_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .word_in    (rdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // Next-state and request capture; word stores skip the read
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          size_d   = req_size;
          signed_d = req_signed;
          write_d  = req_write;
          err_d    = req_err;
          if (req_err) begin
            state_d = ST_RESP;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        rdata_d = mem_dataOut;
        state_d = write_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and request registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      err_q    <= err_d;
    end
  end

  // Outputs are forced quiet while reset is held so nothing leaks mid-reset
  assign req_ready       = reset | (state_q == ST_IDLE);
  assign resp_valid      = !reset && (state_q == ST_RESP);
  assign resp_error      = resp_valid & err_q;
  assign resp_rdata      = (resp_valid && !err_q && !write_q) ? load_data : 32'h0;
  assign mem_address     = reset ? 32'h0 : {2'b00, addr_q[31:2]};
  assign mem_writeEnable = !reset && (state_q == ST_WRITE);
  assign mem_dataIn      = reset ? 32'h0 : store_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a behavioural memory.
module tb_load_store_unit;

  localparam int MEM_WORDS = 1024;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic        mem_writeEnable;
  logic [31:0] mem_dataIn;
  logic [31:0] mem_dataOut;

  logic [31:0] mem [MEM_WORDS];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_error      (resp_error),
    .mem_address     (mem_address),
    .mem_writeEnable (mem_writeEnable),
    .mem_dataIn      (mem_dataIn),
    .mem_dataOut     (mem_dataOut)
  );

  // Memory model: combinational read, synchronous write
  assign mem_dataOut = (mem_address < 32'(MEM_WORDS)) ? mem[mem_address[9:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_writeEnable && (mem_address < 32'(MEM_WORDS))) mem[mem_address[9:0]] <= mem_dataIn;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Per-cycle observations after an accept edge (index n = n-th sample after accept)
  logic        obs_we    [1:8];
  logic        obs_rv    [1:8];
  logic        obs_ready [1:8];
  logic [31:0] obs_addr  [1:8];
  logic [31:0] obs_din   [1:8];
  logic [31:0] obs_rdata [1:8];
  int          lat;
  int          wcount;
  logic [31:0] got_rdata;
  logic        got_err;

  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    check("ready_before_req", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    lat = 0; wcount = 0; got_rdata = 32'h0; got_err = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      #1;
      if (n == 1) req_valid = 1'b0;
      obs_we[n]    = mem_writeEnable;
      obs_rv[n]    = resp_valid;
      obs_ready[n] = req_ready;
      obs_addr[n]  = mem_address;
      obs_din[n]   = mem_dataIn;
      obs_rdata[n] = resp_rdata;
      if (mem_writeEnable) wcount++;
      if (resp_valid && lat == 0) begin
        lat = n; got_rdata = resp_rdata; got_err = resp_error;
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wcyc;   // sample index of the single write, 0 = no write
  } vec_t;

  vec_t vecs[17];

  int          a0, a1, rv_c;
  logic        rdy [12];
  logic        rvv [12];
  logic [31:0] rdd [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, SB, 1'b1, 32'h5,    32'h0,        32'hFFFFFFAA, 1'b0, 2, 0};
    vecs[1]  = '{1'b0, SB, 1'b0, 32'h5,    32'h0,        32'h000000AA, 1'b0, 2, 0};
    vecs[2]  = '{1'b0, SH, 1'b1, 32'h6,    32'h0,        32'hFFFF8899, 1'b0, 2, 0};
    vecs[3]  = '{1'b0, SH, 1'b0, 32'h4,    32'h0,        32'h0000AABB, 1'b0, 2, 0};
    vecs[4]  = '{1'b0, SW, 1'b0, 32'h4,    32'h0,        32'h8899AABB, 1'b0, 2, 0};
    vecs[5]  = '{1'b0, SB, 1'b1, 32'h7,    32'h0,        32'hFFFFFF88, 1'b0, 2, 0};
    vecs[6]  = '{1'b0, SW, 1'b0, 32'h2,    32'h0,        32'h0,        1'b1, 1, 0};
    vecs[7]  = '{1'b0, SB, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1, 1, 0};
    vecs[8]  = '{1'b0, SH, 1'b0, 32'h5,    32'h0,        32'h0,        1'b1, 1, 0};
    vecs[9]  = '{1'b0, SX, 1'b0, 32'h4,    32'h0,        32'h0,        1'b1, 1, 0};
    vecs[10] = '{1'b1, SW, 1'b0, 32'h8,    32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
    vecs[11] = '{1'b0, SW, 1'b0, 32'h8,    32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
    vecs[12] = '{1'b1, SB, 1'b0, 32'hB,    32'h00000055, 32'h0,        1'b0, 3, 2};
    vecs[13] = '{1'b0, SW, 1'b0, 32'h8,    32'h0,        32'h55ADBEEF, 1'b0, 2, 0};
    vecs[14] = '{1'b0, SW, 1'b0, 32'hFFC,  32'h0,        32'h0,        1'b0, 2, 0};
    vecs[15] = '{1'b1, SW, 1'b0, 32'h1000, 32'h12345678, 32'h0,        1'b1, 1, 0};
    vecs[16] = '{1'b0, SB, 1'b1, 32'h9,    32'h0,        32'hFFFFFFBE, 1'b0, 2, 0};

    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
    mem[1] = 32'h8899AABB;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_error", {31'b0, resp_error}, 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_dataIn", mem_dataIn, 32'h0);
    check("rst_we", {31'b0, mem_writeEnable}, 32'h0);
    reset = 1'b0;

    // Table-driven transactions
    for (int i = 0; i < 17; i++) begin
      run_req(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd);
      $display("txn %0d: w=%0d size=%0d signed=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d writes=%0d",
               i, vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, lat, got_rdata, got_err, wcount);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_rdata", i), got_rdata, vecs[i].exp_rd);
      check($sformatf("v%0d_error", i), {31'b0, got_err}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_write_count", i), 32'(wcount), (vecs[i].exp_wcyc != 0) ? 32'h1 : 32'h0);
      if (vecs[i].exp_wcyc != 0) begin
        check($sformatf("v%0d_write_cycle", i), {31'b0, obs_we[vecs[i].exp_wcyc]}, 32'h1);
        check($sformatf("v%0d_write_addr", i), obs_addr[vecs[i].exp_wcyc], {2'b00, vecs[i].a[31:2]});
      end
      if (vecs[i].exp_lat > 1) begin
        check($sformatf("v%0d_rdata_idle_zero", i), obs_rdata[1], 32'h0);
      end
    end
    check("word2_after_word_store", mem[2], 32'h55ADBEEF);

    // Halfword store: read, merged write, then response
    run_req(1'b1, SH, 1'b0, 32'h6, 32'h00001234);
    $display("txn hs: halfword store 1234 @6 -> lat=%0d writes=%0d", lat, wcount);
    check("hs_t1_ready", {31'b0, obs_ready[1]}, 32'h0);
    check("hs_t1_we", {31'b0, obs_we[1]}, 32'h0);
    check("hs_t1_rv", {31'b0, obs_rv[1]}, 32'h0);
    check("hs_t1_addr", obs_addr[1], 32'h1);
    check("hs_t2_we", {31'b0, obs_we[2]}, 32'h1);
    check("hs_t2_din", obs_din[2], 32'h1234AABB);
    check("hs_t2_addr", obs_addr[2], 32'h1);
    check("hs_t2_rv", {31'b0, obs_rv[2]}, 32'h0);
    check("hs_latency", 32'(lat), 32'd3);
    check("hs_t3_we", {31'b0, obs_we[3]}, 32'h0);
    check("hs_write_count", 32'(wcount), 32'h1);
    check("hs_mem1", mem[1], 32'h1234AABB);

    // Reset during the WRITE cycle of a halfword store
    @(negedge clk);
    req_write = 1'b1; req_size = SH; req_signed = 1'b0; req_addr = 32'h4; req_wdata = 32'h5678;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rw_we_gated", {31'b0, mem_writeEnable}, 32'h0);
    check("rw_ready_in_reset", {31'b0, req_ready}, 32'h1);
    check("rw_addr_in_reset", mem_address, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rw_idle_ready", {31'b0, req_ready}, 32'h1);
    check("rw_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rw_mem1_unchanged", mem[1], 32'h1234AABB);
    $display("txn rw: reset during write -> ready=%0d mem1=%h", req_ready, mem[1]);

    // Two loads with req_valid held continuously
    @(negedge clk);
    req_write = 1'b0; req_size = SW; req_signed = 1'b0; req_addr = 32'h4; req_wdata = 32'h0;
    req_valid = 1'b1;
    a0 = -1; a1 = -1; rv_c = -1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      rdy[c] = req_ready; rvv[c] = resp_valid; rdd[c] = resp_rdata;
      if (resp_valid && rv_c < 0) rv_c = c;
      if (a1 >= 0 && c == a1 + 1) req_valid = 1'b0;
      if (req_valid && req_ready) begin
        if (a0 < 0) a0 = c;
        else if (a1 < 0) a1 = c;
      end
    end
    req_valid = 1'b0;
    $display("txn b2b: accepts at %0d and %0d, first resp at %0d", a0, a1, rv_c);
    check("b2b_first_accept", 32'(a0), 32'd0);
    check("b2b_ready_busy1", {31'b0, rdy[1]}, 32'h0);
    check("b2b_ready_busy2", {31'b0, rdy[2]}, 32'h0);
    check("b2b_first_resp", 32'(rv_c), 32'd2);
    check("b2b_first_rdata", rdd[2], 32'h1234AABB);
    check("b2b_accept_gap", 32'(a1 - a0), 32'd3);
    if (a1 >= 0 && a1 + 2 < 12) begin
      check("b2b_second_resp", {31'b0, rvv[a1 + 2]}, 32'h1);
      check("b2b_second_rdata", rdd[a1 + 2], 32'h1234AABB);
    end else begin
      check("b2b_second_accept_seen", 32'(a1), 32'd3);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
